// File: rtl/spi_flash_op_sequencer.sv
// Sequences READ_ID / SECTOR_ERASE / PAGE_PROGRAM flash ops as command dwords
// (WREN, main command, RDSR polls) towards the qspi_mem_controller dword port.
module spi_flash_op_sequencer #(
  parameter int unsigned PAGE_WORDS  = 64,
  parameter bit          USE_QUAD_PP = 1'b0,
  parameter int unsigned POLL_GAP    = 16,
  parameter int unsigned MAX_POLLS   = 1000000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [23:0] req_addr,
  input  logic [31:0] pg_data,
  input  logic        pg_valid,
  output logic        pg_ready,
  output logic        op_done,
  output logic [1:0]  op_err,
  output logic [7:0]  result,
  output logic        dw_wr,
  output logic [31:0] dw_data,
  input  logic        dw_busy,
  input  logic        dw_error,
  input  logic [7:0]  dw_readout
);

  localparam int unsigned CNT_W  = 32;
  localparam logic [7:0]  PP_LEN = 8'(PAGE_WORDS + 1);
  localparam logic [7:0]  PP_CMD = USE_QUAD_PP ? 8'h32 : 8'h02;

  localparam logic [1:0] OP_READ_ID = 2'd0;
  localparam logic [1:0] OP_ERASE   = 2'd1;
  localparam logic [1:0] OP_ILLEGAL = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE, ST_WAIT_RDY, ST_HDR, ST_ADDR, ST_PAYLOAD,
    ST_WAIT_DONE, ST_CHECK, ST_GAP, ST_DONE
  } state_e;

  // Which command of the op is currently in flight.
  typedef enum logic [1:0] {PH_RDID, PH_WREN, PH_MAIN, PH_POLL} phase_e;

  function automatic logic [31:0] hdr_word(input logic quad, input logic [7:0] len,
                                           input logic [7:0] cmd);
    return {15'b0, quad, len, cmd};
  endfunction

  state_e             state_q, state_d;
  phase_e             phase_q, phase_d;
  logic [1:0]         op_q, op_d;
  logic [23:0]        addr_q, addr_d;
  logic [7:0]         pg_cnt_q, pg_cnt_d;
  logic               wait_q, wait_d;
  logic [CNT_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   poll_q, poll_d;
  logic [1:0]         err_q, err_d;
  logic [7:0]         res_q, res_d;
  logic               dw_wr_q, dw_wr_d;
  logic [31:0]        dw_data_q, dw_data_d;
  logic [31:0]        hdr_c;

  always_comb begin : hdr_sel
    hdr_c = '0;
    case (phase_q)
      PH_RDID: hdr_c = hdr_word(1'b0, 8'd0, 8'h9F);
      PH_WREN: hdr_c = hdr_word(1'b0, 8'd0, 8'h06);
      PH_MAIN: hdr_c = (op_q == OP_ERASE) ? hdr_word(1'b0, 8'd1, 8'hD8)
                                          : hdr_word(USE_QUAD_PP, PP_LEN, PP_CMD);
      default: hdr_c = hdr_word(1'b0, 8'd0, 8'h05);
    endcase
  end

  always_comb begin : next_state
    state_d   = state_q;
    phase_d   = phase_q;
    op_d      = op_q;
    addr_d    = addr_q;
    pg_cnt_d  = pg_cnt_q;
    wait_d    = wait_q;
    gap_d     = gap_q;
    poll_d    = poll_q;
    err_d     = err_q;
    res_d     = res_q;
    dw_wr_d   = 1'b0;
    dw_data_d = dw_data_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d   = req_op;
          addr_d = req_addr;
          if (req_op == OP_ILLEGAL) begin
            state_d = ST_DONE;
            err_d   = 2'd3;
            res_d   = 8'h00;
          end else begin
            phase_d = (req_op == OP_READ_ID) ? PH_RDID : PH_WREN;
            state_d = ST_WAIT_RDY;
          end
        end
      end
      ST_WAIT_RDY: if (!dw_busy) state_d = ST_HDR;
      ST_HDR: begin
        wait_d   = 1'b0;
        pg_cnt_d = 8'(PAGE_WORDS);
        state_d  = (phase_q == PH_MAIN) ? ST_ADDR : ST_WAIT_DONE;
      end
      ST_ADDR: state_d = (op_q == OP_ERASE) ? ST_WAIT_DONE : ST_PAYLOAD;
      ST_PAYLOAD: begin
        // Accepted payload words are forwarded on the following cycle.
        if (pg_valid) begin
          dw_wr_d   = 1'b1;
          dw_data_d = pg_data;
          pg_cnt_d  = 8'(pg_cnt_q - 8'd1);
          if (pg_cnt_q == 8'd1) state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!wait_q)       wait_d  = 1'b1;
        else if (!dw_busy) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (dw_error) begin
          state_d = ST_DONE;
          err_d   = 2'd2;
          res_d   = dw_readout;
        end else begin
          case (phase_q)
            PH_RDID: begin
              state_d = ST_DONE;
              err_d   = 2'd0;
              res_d   = dw_readout;
            end
            PH_WREN: begin
              phase_d = PH_MAIN;
              state_d = ST_WAIT_RDY;
            end
            PH_MAIN: begin
              phase_d = PH_POLL;
              poll_d  = '0;
              state_d = ST_WAIT_RDY;
            end
            default: begin
              res_d = dw_readout;
              if (!dw_readout[0]) begin
                state_d = ST_DONE;
                err_d   = 2'd0;
              end else begin
                poll_d = poll_q + CNT_W'(1);
                if ((poll_q + CNT_W'(1)) == CNT_W'(MAX_POLLS)) begin
                  state_d = ST_DONE;
                  err_d   = 2'd1;
                end else begin
                  gap_d   = '0;
                  state_d = (POLL_GAP == 0) ? ST_WAIT_RDY : ST_GAP;
                end
              end
            end
          endcase
        end
      end
      ST_GAP: begin
        if (gap_q == CNT_W'(POLL_GAP - 1)) state_d = ST_WAIT_RDY;
        else                               gap_d   = gap_q + CNT_W'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Header and address strobes are aligned with the registered state.
    if (state_d == ST_HDR) begin
      dw_wr_d   = 1'b1;
      dw_data_d = hdr_c;
    end else if (state_d == ST_ADDR) begin
      dw_wr_d   = 1'b1;
      dw_data_d = {8'h00, addr_q};
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      phase_q   <= PH_RDID;
      op_q      <= 2'd0;
      addr_q    <= '0;
      pg_cnt_q  <= '0;
      wait_q    <= 1'b0;
      gap_q     <= '0;
      poll_q    <= '0;
      err_q     <= 2'd0;
      res_q     <= 8'h00;
      dw_wr_q   <= 1'b0;
      dw_data_q <= '0;
      req_ready <= 1'b1;
      pg_ready  <= 1'b0;
      op_done   <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      pg_cnt_q  <= pg_cnt_d;
      wait_q    <= wait_d;
      gap_q     <= gap_d;
      poll_q    <= poll_d;
      err_q     <= err_d;
      res_q     <= res_d;
      dw_wr_q   <= dw_wr_d;
      dw_data_q <= dw_data_d;
      req_ready <= (state_d == ST_IDLE);
      pg_ready  <= (state_d == ST_PAYLOAD);
      op_done   <= (state_d == ST_DONE);
    end
  end

  assign dw_wr   = dw_wr_q;
  assign dw_data = dw_data_q;
  assign op_err  = err_q;
  assign result  = res_q;

endmodule

// File: tb/tb_spi_flash_op_sequencer.sv
// Bench for spi_flash_op_sequencer: transaction-level controller model plus
// expected dword lists and completion codes derived from the op rules.
module tb_spi_flash_op_sequencer;
  localparam int unsigned PW   = 4;
  localparam int unsigned GAP  = 3;
  localparam int unsigned MAXP = 5;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [23:0] req_addr = '0;
  logic [31:0] pg_data = '0;
  logic        pg_valid = 1'b0;
  logic        pg_ready;
  logic        op_done;
  logic [1:0]  op_err;
  logic [7:0]  result;
  logic        dw_wr;
  logic [31:0] dw_data;
  logic        dw_busy = 1'b0;
  logic        dw_error = 1'b0;
  logic [7:0]  dw_readout = 8'h00;

  always #5 clk_in = ~clk_in;

  spi_flash_op_sequencer #(
    .PAGE_WORDS(PW), .USE_QUAD_PP(1'b1), .POLL_GAP(GAP), .MAX_POLLS(MAXP)
  ) dut (
    .clk_in(clk_in), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .pg_data(pg_data), .pg_valid(pg_valid), .pg_ready(pg_ready),
    .op_done(op_done), .op_err(op_err), .result(result),
    .dw_wr(dw_wr), .dw_data(dw_data), .dw_busy(dw_busy), .dw_error(dw_error),
    .dw_readout(dw_readout)
  );

  int unsigned n_pass = 0, n_fail = 0, n_total = 0;
  int unsigned cyc = 0, viol = 0;
  int unsigned last_acyc = 0, last_dcyc = 0;
  logic [31:0] seen_q[$];
  int unsigned seen_cyc[$];
  logic [7:0]  status_q[$];
  logic [31:0] pg_q[$];
  logic [31:0] pay_ref[$];
  logic [31:0] exp_q[$];
  logic [7:0]  id_byte = 8'h20;
  bit          inj_err = 1'b0;
  int          pg_mode = 3;
  bit          tog = 1'b0;
  int          remaining = 0, busy_cnt = 0;
  logic [7:0]  cur_cmd = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Controller model: logs every dword, busy from header until a short
  // execution after the last dword, then publishes the readout byte.
  always @(posedge clk_in) begin
    if (reset) begin
      dw_busy   <= 1'b0;
      dw_error  <= 1'b0;
      remaining = 0;
      busy_cnt  = 0;
    end else if (dw_wr) begin
      seen_q.push_back(dw_data);
      seen_cyc.push_back(cyc);
      if (remaining == 0) begin
        if (dw_busy) viol++;
        cur_cmd   = dw_data[7:0];
        remaining = int'(dw_data[15:8]);
        dw_busy   <= 1'b1;
      end else begin
        remaining--;
      end
      if (remaining == 0) busy_cnt = 1 + int'($urandom_range(0, 3));
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        dw_busy <= 1'b0;
        if (cur_cmd == 8'h9F) dw_readout <= id_byte;
        if (cur_cmd == 8'h05) begin
          dw_readout <= status_q[0];
          if (status_q.size() > 1) void'(status_q.pop_front());
        end
        if (cur_cmd == 8'h06 && inj_err) dw_error <= 1'b1;
      end
    end
    if (!reset && pg_valid && pg_ready && pg_q.size() > 0) void'(pg_q.pop_front());
    cyc++;
  end

  // Page payload source with selectable valid pattern.
  always @(negedge clk_in) begin
    tog = ~tog;
    if (pg_q.size() > 0) begin
      case (pg_mode)
        0:       pg_valid = 1'b0;
        1:       pg_valid = tog;
        2:       pg_valid = 1'($urandom_range(0, 1));
        default: pg_valid = 1'b1;
      endcase
      pg_data = pg_q[0];
    end else begin
      pg_valid = 1'b0;
      pg_data  = '0;
    end
  end

  task automatic reset_dut();
    @(negedge clk_in);
    reset = 1'b1;
    req_valid = 1'b0;
    inj_err = 1'b0;
    pg_q.delete();
    status_q.delete();
    status_q.push_back(8'h00);
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
  endtask

  task automatic load_payload(input int mode);
    pg_q.delete();
    pay_ref.delete();
    for (int i = 0; i < int'(PW); i++) begin
      pay_ref.push_back($urandom);
      pg_q.push_back(pay_ref[i]);
    end
    pg_mode = mode;
  endtask

  task automatic build_exp(input logic [1:0] op, input logic [23:0] addr, input int polls,
                           input int trunc);
    exp_q.delete();
    if (op == 2'd0) begin
      exp_q.push_back(32'h0000_009F);
    end else begin
      exp_q.push_back(32'h0000_0006);
      if (op == 2'd1) exp_q.push_back(32'h0000_01D8);
      else            exp_q.push_back(32'h0001_0532);
      exp_q.push_back({8'h00, addr});
      if (op == 2'd2) foreach (pay_ref[i]) exp_q.push_back(pay_ref[i]);
      for (int i = 0; i < polls; i++) exp_q.push_back(32'h0000_0005);
    end
    while (trunc >= 0 && exp_q.size() > trunc) void'(exp_q.pop_back());
  endtask

  // Poll outcome from the status script: first clear WIP ends it, else MAXP polls time out.
  task automatic poll_outcome(output int polls, output logic [1:0] err, output logic [7:0] res);
    logic [7:0] s;
    polls = 0; err = 2'd0; res = 8'h00;
    for (int i = 0; i < int'(MAXP); i++) begin
      s = status_q[(i < status_q.size()) ? i : status_q.size() - 1];
      polls = i + 1;
      res = s;
      if (!s[0]) break;
      if (i + 1 == int'(MAXP)) err = 2'd1;
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [23:0] addr, output int unsigned acyc);
    @(negedge clk_in);
    for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk_in);
    req_valid = 1'b1;
    req_op = op;
    req_addr = addr;
    acyc = cyc;
    @(negedge clk_in);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(output bit got, output logic [1:0] err, output logic [7:0] res,
                           output int unsigned dcyc);
    got = 1'b0; err = 2'd0; res = 8'h00; dcyc = 0;
    for (int i = 0; i < 4000; i++) begin
      if (op_done) begin
        got = 1'b1; err = op_err; res = result; dcyc = cyc;
        break;
      end
      @(negedge clk_in);
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [23:0] addr,
                       input int polls, input logic [1:0] err_e, input logic [7:0] res_e,
                       input bit chk_res, input int trunc);
    int unsigned a, d;
    bit got;
    logic [1:0] err;
    logic [7:0] res;
    seen_q.delete();
    seen_cyc.delete();
    build_exp(op, addr, polls, trunc);
    issue(op, addr, a);
    wait_done(got, err, res, d);
    check({tag, " done"}, 32'(got), 32'd1);
    check({tag, " err"}, 32'(err), 32'(err_e));
    if (chk_res) check({tag, " result"}, 32'(res), 32'(res_e));
    repeat (3) @(negedge clk_in);
    check({tag, " ndw"}, seen_q.size(), exp_q.size());
    for (int i = 0; i < seen_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s dw%0d", tag, i), seen_q[i], exp_q[i]);
    last_acyc = a;
    last_dcyc = d;
  endtask

  initial begin
    int polls, last;
    logic [1:0] err_e;
    logic [7:0] res_e;
    logic [1:0] op;
    logic [23:0] addr;
    int nb;
    bit reached;
    int unsigned a;
    int bad;

    status_q.push_back(8'h00);
    repeat (3) @(negedge clk_in);
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst dw_wr", 32'(dw_wr), 32'd0);
    check("rst dw_data", dw_data, 32'd0);
    check("rst pg_ready", 32'(pg_ready), 32'd0);
    check("rst op_done", 32'(op_done), 32'd0);
    check("rst op_err", 32'(op_err), 32'd0);
    check("rst result", 32'(result), 32'd0);
    reset = 1'b0;

    // READ_ID with header latency
    id_byte = 8'h20;
    do_op("rdid", 2'd0, 24'h0, 0, 2'd0, 8'h20, 1'b1, -1);
    if (seen_cyc.size() > 0) check("rdid latency", seen_cyc[0] - last_acyc, 32'd2);

    // SECTOR_ERASE with two busy polls
    status_q.delete();
    status_q.push_back(8'h03); status_q.push_back(8'h03); status_q.push_back(8'h00);
    do_op("erase", 2'd1, 24'h012000, 3, 2'd0, 8'h00, 1'b1, -1);
    last = -1;
    for (int i = 0; i < seen_q.size(); i++) begin
      if (seen_q[i] == 32'h5) begin
        if (last >= 0) check("erase poll gap", 32'((seen_cyc[i] - seen_cyc[last]) > GAP), 32'd1);
        last = i;
      end
    end

    // PAGE_PROGRAM with pg_valid toggling
    status_q.delete();
    status_q.push_back(8'h01); status_q.push_back(8'h00);
    load_payload(1);
    do_op("prog", 2'd2, 24'h3456AB, 2, 2'd0, 8'h00, 1'b1, -1);

    // WIP stuck: poll timeout
    status_q.delete();
    status_q.push_back(8'h01);
    do_op("stuck", 2'd1, 24'h00F000, int'(MAXP), 2'd1, 8'h01, 1'b1, -1);

    // Controller error right after WREN
    reset_dut();
    inj_err = 1'b1;
    load_payload(3);
    do_op("ctlerr", 2'd2, 24'h000100, 0, 2'd2, 8'h00, 1'b0, 1);
    reset_dut();

    // Illegal op
    do_op("illegal", 2'd3, 24'h0, 0, 2'd3, 8'h00, 1'b0, 0);
    check("illegal done cycle", last_dcyc - last_acyc, 32'd1);

    // Reset during PAYLOAD, with a request ignored while busy
    reset_dut();
    load_payload(0);
    seen_q.delete();
    seen_cyc.delete();
    issue(2'd2, 24'h0A0B0C, a);
    reached = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (pg_ready) begin reached = 1'b1; break; end
      @(negedge clk_in);
    end
    check("midrst payload reached", 32'(reached), 32'd1);
    check("midrst req_ready busy", 32'(req_ready), 32'd0);
    req_valid = 1'b1; req_op = 2'd0;
    repeat (2) @(negedge clk_in);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk_in);
    check("midrst dw_wr", 32'(dw_wr), 32'd0);
    check("midrst pg_ready", 32'(pg_ready), 32'd0);
    check("midrst req_ready", 32'(req_ready), 32'd1);
    check("midrst op_done", 32'(op_done), 32'd0);
    reset = 1'b0;
    pg_q.delete();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (op_done || dw_wr) bad++;
    end
    check("midrst quiet after", 32'(bad), 32'd0);
    check("midrst ndw", seen_q.size(), 32'd3);
    reset_dut();

    // Randomized ops against the outcome model
    for (int t = 0; t < 8; t++) begin
      op = 2'($urandom_range(0, 2));
      addr = 24'($urandom);
      id_byte = 8'($urandom);
      status_q.delete();
      nb = int'($urandom_range(0, 6));
      for (int i = 0; i < nb; i++) status_q.push_back(8'($urandom) | 8'h01);
      status_q.push_back(8'($urandom) & 8'hFE);
      if (op == 2'd2) load_payload(int'($urandom_range(1, 3)));
      if (op == 2'd0) begin
        polls = 0; err_e = 2'd0; res_e = id_byte;
      end else begin
        poll_outcome(polls, err_e, res_e);
      end
      do_op($sformatf("rand%0d", t), op, addr, polls, err_e, res_e, 1'b1, -1);
    end

    check("no dw_wr while busy", viol, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
